// File: rtl/j1_pkg.sv
// j1_pkg: shared definitions for the core's operand-1 path.
//   OP1_* : op1_sel encodings, shared with the operand-1 mux.
//   io_rd_state_t : states of the I/O read sequencer.
package j1_pkg;

  localparam logic [1:0] OP1_ST0  = 2'b00;
  localparam logic [1:0] OP1_RST0 = 2'b01;
  localparam logic [1:0] OP1_MEM  = 2'b10;
  localparam logic [1:0] OP1_IO   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } io_rd_state_t;

endpackage

// File: rtl/io_timeout_counter.sv
// io_timeout_counter: counts bus wait cycles for the I/O read sequencer.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the count (takes priority over enable)
//   enable   : advance the count by one
//   expired  : count has reached TIMEOUT_CYCLES-1
module io_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/io_read_sequencer.sv
// io_read_sequencer: stalls the core while an io_din operand is fetched.
// An instruction selecting io_din (op1_sel = OP1_IO, not immediate) holds the
// core in stall, issues a level read request on the I/O bus, captures the
// acknowledged word into io_din, then releases the core for one DONE cycle in
// which the instruction retires.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   insn_valid    : decoded instruction present
//   is_immediate  : instruction is a literal
//   op1_sel       : operand-1 select
//   io_addr       : read address (st0)
//   io_rd         : registered read request (level, held until ack/abort)
//   io_rd_addr    : registered read address, stable while io_rd=1
//   io_ack        : one-cycle acknowledge qualifying io_rdata
//   io_rdata      : bus read data
//   io_din        : captured word for the operand mux
//   stall         : combinational core freeze
//   err_clr       : clears timeout_err
//   timeout_err   : sticky timeout flag
//
// Handshake: io_rd rises the cycle after the trigger and stays high with a
// frozen io_rd_addr until the bus returns io_ack for exactly one cycle; that
// cycle's io_rdata is the read result. io_ack outside WAIT is ignored.
//
// Build option: define IO_TIMEOUT_EN to abort a read after TIMEOUT_CYCLES
// wait cycles, returning TIMEOUT_VALUE and setting timeout_err.
module io_read_sequencer
  import j1_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter int               TIMEOUT_CYCLES = 255,
  parameter logic [WIDTH-1:0] TIMEOUT_VALUE  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             insn_valid,
  input  logic             is_immediate,
  input  logic [1:0]       op1_sel,
  input  logic [WIDTH-1:0] io_addr,
  output logic             io_rd,
  output logic [WIDTH-1:0] io_rd_addr,
  input  logic             io_ack,
  input  logic [WIDTH-1:0] io_rdata,
  output logic [WIDTH-1:0] io_din,
  output logic             stall,
  input  logic             err_clr,
  output logic             timeout_err
);

  io_rd_state_t state_q;
  io_rd_state_t state_d;
  logic         rd_hit;
  logic         timeout_fire;

  assign rd_hit = insn_valid && !is_immediate && (op1_sel == OP1_IO);

`ifdef IO_TIMEOUT_EN
  logic cnt_expired;

  io_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state_q == IDLE) && rd_hit),
    .enable  ((state_q == WAIT) && !io_ack),
    .expired (cnt_expired)
  );

  // An ack on the expiry cycle wins: the read completes normally.
  assign timeout_fire = (state_q == WAIT) && !io_ack && cnt_expired;

  // Set has priority over clear so a timeout is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (timeout_fire) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end
`else
  logic [32:0] unused_cfg;

  assign unused_cfg   = {err_clr, 32'(TIMEOUT_CYCLES)};
  assign timeout_fire = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = rd_hit;
        if (rd_hit) state_d = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (io_ack || timeout_fire) state_d = DONE;
      end
      // Held instruction retires here; rd_hit is deliberately ignored.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_rd      <= 1'b0;
      io_rd_addr <= '0;
      io_din     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_hit) begin
            io_rd_addr <= io_addr;
            io_rd      <= 1'b1;
          end
        end
        WAIT: begin
          if (io_ack) begin
            io_din <= io_rdata;
            io_rd  <= 1'b0;
          end else if (timeout_fire) begin
            io_din <= TIMEOUT_VALUE;
            io_rd  <= 1'b0;
          end
        end
        default: io_rd <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_read_sequencer.sv
// tb_io_read_sequencer: directed self-checking bench for io_read_sequencer.
// Timeout cases are compiled in when IO_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4).
module tb_io_read_sequencer;
  import j1_pkg::*;

  localparam int W = 32;
`ifdef IO_TIMEOUT_EN
  localparam int SLOW_N = 3;
`else
  localparam int SLOW_N = 5;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         insn_valid = 1'b0;
  logic         is_immediate = 1'b0;
  logic [1:0]   op1_sel = OP1_ST0;
  logic [W-1:0] io_addr = '0;
  logic         io_rd;
  logic [W-1:0] io_rd_addr;
  logic         io_ack = 1'b0;
  logic [W-1:0] io_rdata = '0;
  logic [W-1:0] io_din;
  logic         stall;
  logic         err_clr = 1'b0;
  logic         timeout_err;

  io_read_sequencer #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_VALUE  ({W{1'b1}})
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .insn_valid   (insn_valid),
    .is_immediate (is_immediate),
    .op1_sel      (op1_sel),
    .io_addr      (io_addr),
    .io_rd        (io_rd),
    .io_rd_addr   (io_rd_addr),
    .io_ack       (io_ack),
    .io_rdata     (io_rdata),
    .io_din       (io_din),
    .stall        (stall),
    .err_clr      (err_clr),
    .timeout_err  (timeout_err)
  );

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_din = '0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full read: ack arrives on WAIT cycle n. Expects n+1 stall cycles.
  task automatic do_read(input logic [W-1:0] addr, input logic [W-1:0] data, input int n);
    int stalls;
    stalls = 0;
    exp_q.push_back(data);
    insn_valid = 1'b1; is_immediate = 1'b0; op1_sel = OP1_IO; io_addr = addr;
    @(negedge clk);
    if (stall) stalls++;
    check_eq("trig_io_rd", 32'(io_rd), 32'd0);
    cyc();
    for (int w = 1; w <= n; w++) begin
      io_addr = $urandom;
      if (w == n) begin
        io_ack = 1'b1;
        io_rdata = data;
      end
      @(negedge clk);
      if (stall) stalls++;
      check_eq("wait_io_rd", 32'(io_rd), 32'd1);
      check_eq("wait_addr", io_rd_addr, addr);
      cyc();
      io_ack = 1'b0;
      io_rdata = $urandom;
    end
    // DONE: instruction still held by the core
    @(negedge clk);
    if (stall) stalls++;
    exp_din = exp_q.pop_front();
    check_eq("done_stall", 32'(stall), 32'd0);
    check_eq("done_io_rd", 32'(io_rd), 32'd0);
    check_eq("done_din", io_din, exp_din);
    check_eq("done_state", 32'(dut.state_q), 32'(DONE));
    check_eq("stall_cycles", 32'(stalls), 32'(n + 1));
    cyc();
    insn_valid = 1'b0;
    @(negedge clk);
    check_eq("no_retrigger", 32'(io_rd), 32'd0);
    check_eq("idle_state", 32'(dut.state_q), 32'(IDLE));
    cyc();
  endtask

  initial begin
    // reset
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_io_rd", 32'(io_rd), 32'd0);
    check_eq("rst_addr", io_rd_addr, 32'h0);
    check_eq("rst_din", io_din, 32'h0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_err", 32'(timeout_err), 32'd0);
    check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
    cyc();

    // basic read
    do_read(32'h0000_1000, 32'hDEAD_BEEF, 1);

    // non-IO and immediate instructions do not trigger
    insn_valid = 1'b1; op1_sel = OP1_MEM; is_immediate = 1'b0;
    @(negedge clk);
    check_eq("mem_stall", 32'(stall), 32'd0);
    cyc();
    op1_sel = OP1_IO; is_immediate = 1'b1;
    @(negedge clk);
    check_eq("imm_stall", 32'(stall), 32'd0);
    check_eq("mem_io_rd", 32'(io_rd), 32'd0);
    cyc();
    insn_valid = 1'b0; is_immediate = 1'b0;
    @(negedge clk);
    check_eq("imm_io_rd", 32'(io_rd), 32'd0);
    cyc();

    // slow bus, then back-to-back restart
    do_read(32'h0000_2040, 32'h0BAD_F00D, SLOW_N);
    do_read(32'h0000_3000, 32'h1357_9BDF, 2);

    // spurious ack in IDLE
    io_ack = 1'b1; io_rdata = 32'h0000_1234;
    cyc();
    io_ack = 1'b0;
    @(negedge clk);
    check_eq("spurious_din", io_din, exp_din);
    check_eq("spurious_io_rd", 32'(io_rd), 32'd0);
    cyc();

    // reset on the 3rd WAIT cycle, then a late ack
    insn_valid = 1'b1; op1_sel = OP1_IO; io_addr = 32'h0000_4000;
    cyc(); cyc(); cyc();
    rst = 1'b1;
    @(negedge clk);
    check_eq("prerst_io_rd", 32'(io_rd), 32'd1);
    cyc();
    rst = 1'b0; insn_valid = 1'b0;
    io_ack = 1'b1; io_rdata = 32'hCAFE_CAFE;
    @(negedge clk);
    check_eq("midrst_io_rd", 32'(io_rd), 32'd0);
    check_eq("midrst_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("midrst_din", io_din, 32'h0);
    cyc();
    io_ack = 1'b0;
    @(negedge clk);
    check_eq("lateack_din", io_din, 32'h0);
    check_eq("lateack_io_rd", 32'(io_rd), 32'd0);
    cyc();

`ifdef IO_TIMEOUT_EN
    // no ack: abort after 4 WAIT cycles
    insn_valid = 1'b1; op1_sel = OP1_IO; io_addr = 32'h0000_5000;
    cyc();
    for (int w = 1; w <= 4; w++) begin
      @(negedge clk);
      check_eq("to_wait_io_rd", 32'(io_rd), 32'd1);
      check_eq("to_wait_err", 32'(timeout_err), 32'd0);
      cyc();
    end
    @(negedge clk);
    check_eq("to_din", io_din, 32'hFFFF_FFFF);
    check_eq("to_err", 32'(timeout_err), 32'd1);
    check_eq("to_io_rd", 32'(io_rd), 32'd0);
    check_eq("to_stall", 32'(stall), 32'd0);
    cyc();
    insn_valid = 1'b0;
    @(negedge clk);
    check_eq("to_err_sticky", 32'(timeout_err), 32'd1);
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    @(negedge clk);
    check_eq("to_err_clr", 32'(timeout_err), 32'd0);
    cyc();
    // ack on the expiry cycle wins
    do_read(32'h0000_6000, 32'h2468_ACE0, 4);
    @(negedge clk);
    check_eq("ack_wins_err", 32'(timeout_err), 32'd0);
    cyc();
`else
    // without the timeout, err_clr has no effect and the flag stays low
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    @(negedge clk);
    check_eq("no_to_err", 32'(timeout_err), 32'd0);
    cyc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_read_sequencer.md
Name: io_read_sequencer

Overview:
- Sequences the I/O-input leg of the core's operand-1 mux (st0 / rst0 / mem_din / io_din / immediate).
- Detects an instruction that selects io_din (op1_sel = 2'b11, not immediate) and stalls the core.
- Performs a request/acknowledge read on the I/O bus, registers the returned word, then releases the core so the instruction completes with valid io_din.
- Sits between core decode and the I/O bus fabric.

Parameters:
- WIDTH, 32, data/address width; matches operand width.
- TIMEOUT_CYCLES, 255, max WAIT cycles before abort; only used with IO_TIMEOUT_EN; legal range 2..65535.
- TIMEOUT_VALUE, all ones, word returned on timeout; only used with IO_TIMEOUT_EN.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- insn_valid  in  1  decoded instruction present this cycle
- is_immediate  in  1  instruction is a literal
- op1_sel  in  2  operand-1 select; 2'b11 = io_din
- io_addr  in  WIDTH  I/O address (st0) for the read
- io_rd  out  1  registered bus read request, level
- io_rd_addr  out  WIDTH  registered address, stable while io_rd=1
- io_ack  in  1  bus acknowledge, one cycle, qualifies io_rdata
- io_rdata  in  WIDTH  bus read data
- io_din  out  WIDTH  registered word to operand mux
- stall  out  1  freeze core (combinational)
- err_clr  in  1  clears timeout_err
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, io_rd=0, io_rd_addr=0, io_din=0, timeout_err=0, counter=0.
- Trigger: rd_hit = insn_valid & ~is_immediate & (op1_sel == 2'b11).
- States:
  - IDLE: stall = rd_hit. On rd_hit: latch io_rd_addr <= io_addr, set io_rd <= 1, go to WAIT.
  - WAIT: stall=1, io_rd=1. On io_ack: io_din <= io_rdata, io_rd <= 0, go to DONE.
  - DONE: stall=0, io_rd=0, io_din valid; the core consumes it and retires the instruction. rd_hit is ignored, so the held instruction does not retrigger. Go to IDLE unconditionally.
- Latency: decode at cycle T (stall). Earliest ack at T+1 gives DONE at T+2. Minimum 2 stall cycles; each extra WAIT cycle adds 1.
- io_ack outside WAIT is ignored; io_din is unchanged.
- io_din holds its value until the next successful capture or timeout.
- Inputs are don't-care in WAIT; io_rd_addr never changes in WAIT.
- Reset mid-transaction: io_rd drops at the reset edge; a later ack is ignored.
- err_clr: sets timeout_err <= 0 in any state. If a timeout and err_clr occur in the same cycle, the set wins.

Optional Feature:
- Macro: IO_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack: io_din <= TIMEOUT_VALUE, timeout_err <= 1, io_rd <= 0, go to DONE.
  - Ack and timeout in the same cycle: ack wins, no error.
- Without the macro: WAIT persists until ack, timeout_err is tied 0, err_clr is ignored, no counter logic exists.

Decomposition:
- Shared package j1_pkg holds:
  - op1_sel encoding constants OP1_ST0=2'b00, OP1_RST0=2'b01, OP1_MEM=2'b10, OP1_IO=2'b11, also used by the operand mux;
  - state enum io_rd_state_t {IDLE, WAIT, DONE}.
- One sub-module, io_timeout_counter: clear/enable/expired, width $clog2(TIMEOUT_CYCLES). Instantiated only under IO_TIMEOUT_EN.

Test Plan:
- Basic read: insn_valid=1, op1_sel=2'b11, io_addr=0x1000, ack 1 cycle after io_rd with io_rdata=0xDEADBEEF -> stall high 2 cycles, io_rd_addr=0x1000, io_din=0xDEADBEEF in DONE, stall=0.
- Non-IO and immediate: op1_sel=2'b10, then is_immediate=1 with op1_sel=2'b11 -> stall=0, io_rd never asserted.
- Slow bus: ack after 5 WAIT cycles -> stall for 6 cycles total, io_rd_addr stable throughout, no retrigger in DONE, next IO instruction in the following IDLE restarts the sequence.
- Spurious ack in IDLE with io_rdata=0x1234 -> io_din unchanged.
- Reset mid-WAIT: assert rst at the 3rd WAIT cycle, then ack -> io_rd=0, state IDLE, io_din=0.
- Timeout (IO_TIMEOUT_EN, TIMEOUT_CYCLES=4): no ack -> after 4 WAIT cycles io_din=0xFFFFFFFF and timeout_err=1. err_clr then clears it. A repeat run with ack on the expiry cycle gives no error.
